// File: rtl/r_modexp_ctrl.sv
// r_modexp_ctrl: right-to-left binary square-and-multiply controller that
// computes m = c^d mod n using an external shared modular multiplier.
module r_modexp_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] c,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [DATA_WIDTH-1:0] n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] m,
  output logic                  mul_req,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  output logic [DATA_WIDTH-1:0] mul_n,
  input  logic                  mul_ack,
  input  logic [DATA_WIDTH-1:0] mul_result
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    WAIT_MUL,
    SQR,
    WAIT_SQR,
    SHIFT,
    FIN
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] e;
  logic [DATA_WIDTH-1:0] cap_c;

  // Control FSM with registered outputs; mul_n doubles as the captured modulus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      m       <= '0;
      mul_req <= 1'b0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_n   <= '0;
      acc     <= '0;
      b       <= '0;
      e       <= '0;
      cap_c   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            cap_c <= c;
            mul_n <= n;
            acc   <= DATA_WIDTH'(1);
            b     <= c;
            e     <= d;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if ((mul_n < DATA_WIDTH'(2)) || (cap_c >= mul_n)) begin
            m     <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            state <= FIN;
          end else if (e == '0) begin
            m     <= DATA_WIDTH'(1);
            done  <= 1'b1;
            state <= FIN;
          end else if (e[0]) begin
            state <= MUL;
          end else begin
            state <= SQR;
          end
        end
        MUL: begin
          mul_a   <= acc;
          mul_b   <= b;
          mul_req <= 1'b1;
          state   <= WAIT_MUL;
        end
        WAIT_MUL: begin
          if (mul_ack) begin
            acc     <= mul_result;
            mul_req <= 1'b0;
            // Skip the square after the last set bit.
            state   <= (e == DATA_WIDTH'(1)) ? SHIFT : SQR;
          end
        end
        SQR: begin
          mul_a   <= b;
          mul_b   <= b;
          mul_req <= 1'b1;
          state   <= WAIT_SQR;
        end
        WAIT_SQR: begin
          if (mul_ack) begin
            b       <= mul_result;
            mul_req <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          e <= e >> 1;
          if ((e >> 1) == '0) begin
            m     <= acc;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            state <= CHECK;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          mul_a <= '0;
          mul_b <= '0;
          mul_n <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_modexp_ctrl.sv
// tb_r_modexp_ctrl: vector table plus randomized operands against a plain
// arithmetic modexp reference, with a latency-configurable modmul model.
module tb_r_modexp_ctrl;

  localparam int DW    = 32;
  localparam int LIMIT = 5000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] c, d, n;
  logic          busy, done, err;
  logic [DW-1:0] m;
  logic          mul_req;
  logic [DW-1:0] mul_a, mul_b, mul_n;
  logic          mul_ack;
  logic [DW-1:0] mul_result;

  int nchk;
  int nfail;
  int req_edges;
  int lat_fixed;
  bit spur_en;

  r_modexp_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c), .d(d), .n(n),
    .busy(busy), .done(done), .err(err), .m(m),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
    .mul_ack(mul_ack), .mul_result(mul_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Modular multiplier model: one request at a time, ack after lat cycles.
  logic [DW-1:0] pa, pb, pn;
  bit            pend;
  bit            ack_prev;
  int            cnt;
  initial begin
    pend = 0; ack_prev = 0; cnt = 0; req_edges = 0;
    mul_ack = 1'b0; mul_result = '0;
  end
  always @(negedge clk) begin
    mul_ack = 1'b0;
    if (pend && mul_req) begin
      nchk++;
      if (mul_a !== pa || mul_b !== pb || mul_n !== pn) begin
        nfail++;
        $display("FAIL operand_stable: got %0d/%0d/%0d required %0d/%0d/%0d",
                 mul_a, mul_b, mul_n, pa, pb, pn);
      end
    end
    if (ack_prev) begin
      nchk++;
      if (mul_req !== 1'b0) begin
        nfail++;
        $display("FAIL req_drop_after_ack: got %0d required 0", mul_req);
      end
    end
    if (!pend && !ack_prev && mul_req === 1'b1) begin
      pend = 1;
      pa = mul_a; pb = mul_b; pn = mul_n;
      cnt = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 20);
      req_edges++;
    end
    ack_prev = 0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mul_ack    = 1'b1;
        mul_result = (pn == 0) ? '0 : DW'((64'(pa) * 64'(pb)) % 64'(pn));
        pend       = 0;
        ack_prev   = 1;
      end
    end else if (spur_en && mul_req !== 1'b1 && $urandom_range(0, 3) == 0) begin
      mul_ack    = 1'b1;
      mul_result = $urandom;
    end
  end

  function automatic void ref_modexp(input logic [DW-1:0] ci, di, ni,
                                     output logic [DW-1:0] mo, output logic eo);
    longint unsigned r, base;
    if (ni < 2 || ci >= ni) begin
      mo = '0; eo = 1'b1;
      return;
    end
    eo = 1'b0; r = 1; base = ci;
    for (int i = 0; i < DW; i++) begin
      if (di[i]) r = (r * base) % ni;
      base = (base * base) % ni;
    end
    mo = DW'(r);
  endfunction

  function automatic int ref_reqs(input logic [DW-1:0] ci, di, ni);
    int pc, bl;
    if (ni < 2 || ci >= ni || di == 0) return 0;
    pc = 0; bl = 0;
    for (int i = 0; i < DW; i++) if (di[i]) begin pc++; bl = i + 1; end
    return pc + bl - 1;
  endfunction

  task automatic run_op(input logic [DW-1:0] ci, di, ni, input bit noisy,
                        output logic [DW-1:0] mo, output logic eo,
                        output int cyc, output int reqs);
    int r0;
    @(negedge clk);
    start = 1'b1; c = ci; d = di; n = ni;
    r0 = req_edges;
    @(negedge clk);
    start = 1'b0; c = $urandom; d = $urandom; n = $urandom;
    cyc = 1;
    chk("busy_rise", busy, 1);
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (noisy) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("busy_in_fin", busy, 1);
    mo = m; eo = err; reqs = req_edges - r0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_fall", busy, 0);
  endtask

  typedef struct {
    logic [DW-1:0] c, d, n, m;
    logic          e;
    int            reqs;
    int            cyc;
  } vec_t;

  initial begin
    vec_t          vt[10];
    logic [DW-1:0] mo, em, rc, rd, rn;
    logic          eo, ee;
    int            cyc, reqs, dones, pulses;

    vt[0] = '{c:2790, d:2753, n:3233, m:65,   e:0, reqs:16, cyc:-1};
    vt[1] = '{c:65,   d:17,   n:3233, m:2790, e:0, reqs:6,  cyc:-1};
    vt[2] = '{c:5,    d:0,    n:7,    m:1,    e:0, reqs:0,  cyc:2};
    vt[3] = '{c:5,    d:3,    n:1,    m:0,    e:1, reqs:0,  cyc:2};
    vt[4] = '{c:7,    d:3,    n:7,    m:0,    e:1, reqs:0,  cyc:2};
    vt[5] = '{c:3,    d:1,    n:7,    m:3,    e:0, reqs:1,  cyc:-1};
    vt[6] = '{c:0,    d:5,    n:7,    m:0,    e:0, reqs:4,  cyc:-1};
    vt[7] = '{c:4,    d:13,   n:497,  m:445,  e:0, reqs:6,  cyc:-1};
    vt[8] = '{c:6,    d:2,    n:7,    m:1,    e:0, reqs:2,  cyc:-1};
    vt[9] = '{c:3,    d:5,    n:0,    m:0,    e:1, reqs:0,  cyc:2};

    nchk = 0; nfail = 0;
    lat_fixed = 3; spur_en = 0;
    rst_n = 1'b0; start = 1'b0; c = '0; d = '0; n = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_m", m, 0);
    chk("rst_mul_req", mul_req, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_mul_n", mul_n, 0);
    rst_n = 1'b1;

    // Directed table, fixed 3-cycle multiplier.
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].c, vt[i].d, vt[i].n, 1'b0, mo, eo, cyc, reqs);
      chk($sformatf("vec%0d_m", i), mo, vt[i].m);
      chk($sformatf("vec%0d_err", i), eo, vt[i].e);
      chk($sformatf("vec%0d_reqs", i), reqs, vt[i].reqs);
      if (vt[i].cyc >= 0) chk($sformatf("vec%0d_cycles", i), cyc, vt[i].cyc);
      chk($sformatf("vec%0d_idle_mul_n", i), mul_n, 0);
    end

    // Randomized operands, latency 1..20, spurious acks, start noise mid-op.
    lat_fixed = 0; spur_en = 1;
    for (int i = 0; i < 30; i++) begin
      rn = $urandom;
      if (i % 8 == 0) rn = $urandom_range(0, 3);
      rc = (i % 5 == 0 || rn == 0) ? DW'($urandom) : DW'($urandom % rn);
      rd = $urandom_range(0, 65535);
      if (i % 7 == 3) rd = 0;
      ref_modexp(rc, rd, rn, em, ee);
      run_op(rc, rd, rn, 1'b1, mo, eo, cyc, reqs);
      chk($sformatf("rnd%0d_m", i), mo, em);
      chk($sformatf("rnd%0d_err", i), eo, ee);
      chk($sformatf("rnd%0d_reqs", i), reqs, ref_reqs(rc, rd, rn));
    end
    spur_en = 0;
    repeat (25) @(negedge clk);

    // Reset while waiting on the first square; the late ack must be ignored.
    lat_fixed = 6;
    @(negedge clk);
    start = 1'b1; c = 2790; d = 2753; n = 3233;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(mul_req && mul_a == mul_b) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_sqr", (mul_req && mul_a == mul_b), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_mul_req", mul_req, 0);
    chk("abort_mul_a", mul_a, 0);
    chk("abort_mul_n", mul_n, 0);
    chk("abort_m", m, 0);
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    lat_fixed = 3;
    run_op(4, 13, 497, 1'b0, mo, eo, cyc, reqs);
    chk("post_reset_m", mo, 445);
    chk("post_reset_err", eo, 0);

    // start held high: three back-to-back operations.
    @(negedge clk);
    start = 1'b1; c = 65; d = 17; n = 3233;
    dones = 0; cyc = 0;
    while (dones < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        dones++;
        chk($sformatf("b2b%0d_m", dones), m, 2790);
        @(negedge clk);
        cyc++;
        chk($sformatf("b2b%0d_idle_gap", dones), busy, 0);
        if (dones == 3) start = 1'b0;
        @(negedge clk);
        cyc++;
        chk($sformatf("b2b%0d_busy_next", dones), busy, (dones < 3) ? 1 : 0);
      end
    end
    start = 1'b0;
    chk("b2b_done_count", dones, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
